// File: rtl/csa_accum_seq.sv
// Batch accumulator: operands are summed in carry-save form (S, C) so the
// per-operand path has no carry-propagate adder; the single full add happens
// once per batch in the RESOLVE state before the result is offered.
module csa_accum_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ACC_W = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_cnt_sat
);

    typedef enum logic [1:0] {StIdle, StAccum, StResolve, StDone} state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   s_q, s_d;
    logic [ACC_W-1:0]   c_q, c_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   ocnt_q, ocnt_d;
    logic               osat_q, osat_d;

    logic               in_hs;
    logic               out_hs;
    logic [ACC_W-1:0]   operand;
    logic [ACC_W-1:0]   csa_sum;
    logic [ACC_W-1:0]   csa_maj;
    logic [ACC_W-1:0]   csa_carry;
    logic               cnt_max;

    // Handshake flags depend only on state, so no combinational path from inputs to in_ready.
    assign in_ready  = (state_q == StIdle) || (state_q == StAccum);
    assign out_valid = (state_q == StDone);
    assign in_hs     = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;

    assign out_sum     = sum_q;
    assign out_count   = ocnt_q;
    assign out_cnt_sat = osat_q;

    // 3:2 compressor folding the new operand into the carry-save pair.
    always_comb begin
        operand   = ACC_W'(in_data);
        csa_sum   = s_q ^ c_q ^ operand;
        csa_maj   = (s_q & c_q) | (s_q & operand) | (c_q & operand);
        csa_carry = csa_maj << 1;
        cnt_max   = &cnt_q;
    end

    // Next-state logic: accept operands, resolve once, hold result until taken.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        sum_d   = sum_q;
        ocnt_d  = ocnt_q;
        osat_d  = osat_q;

        unique case (state_q)
            StIdle: begin
                if (in_hs) begin
                    s_d     = operand;
                    c_d     = '0;
                    cnt_d   = CNT_W'(1);
                    sat_d   = 1'b0;
                    state_d = in_last ? StResolve : StAccum;
                end
            end
            StAccum: begin
                if (in_hs) begin
                    s_d = csa_sum;
                    c_d = csa_carry;
                    // Count clamps at all-ones; the sticky flag marks the batch as overrun.
                    if (cnt_max) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (in_last) begin
                        state_d = StResolve;
                    end
                end
            end
            StResolve: begin
                sum_d   = s_q + c_q;
                ocnt_d  = cnt_q;
                osat_d  = sat_q;
                state_d = StDone;
            end
            StDone: begin
                if (out_hs) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous reset taking priority over any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            s_q     <= '0;
            c_q     <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            sum_q   <= '0;
            ocnt_q  <= '0;
            osat_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            sum_q   <= sum_d;
            ocnt_q  <= ocnt_d;
            osat_q  <= osat_d;
        end
    end

endmodule

// File: tb/tb_csa_accum_seq.sv
// Directed and randomized checks of the carry-save batch accumulator.
module tb_csa_accum_seq;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned ACC_W = 16;
    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_cnt_sat;

    int total;
    int bad;

    csa_accum_seq #(
        .WIDTH(WIDTH),
        .ACC_W(ACC_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_count  (out_count),
        .out_cnt_sat(out_cnt_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sample point is 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operand and hold it until accepted (bounded).
    task automatic send(input logic [WIDTH-1:0] d, input logic last);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && waited < 50) begin
            step();
            waited++;
        end
        total++;
        if (!in_ready) begin
            bad++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'hC3;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        total++;
        if ({in_ready, out_valid, out_sum, out_count, out_cnt_sat} !== {1'b1, 1'b0, 16'h0, 8'h0, 1'b0}) begin
            bad++;
            $display("FAIL reset: rdy=%0b vld=%0b sum=%h cnt=%0d sat=%0b required 1 0 0000 0 0",
                     in_ready, out_valid, out_sum, out_count, out_cnt_sat);
        end
    endtask

    task automatic test_single();
        send(8'h5A, 1'b1);
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_resolve: rdy=%0b vld=%0b required 0 0", in_ready, out_valid);
        end
        step();
        total++;
        if ({out_valid, out_sum, out_count, out_cnt_sat} !== {1'b1, 16'h005A, 8'd1, 1'b0}) begin
            bad++;
            $display("FAIL single_result: vld=%0b sum=%h cnt=%0d sat=%0b required 1 005a 1 0",
                     out_valid, out_sum, out_count, out_cnt_sat);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL single_release: vld=%0b rdy=%0b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hFF;
            in_last  = (i == 3);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_resolve_rdy: in_ready=%0b required 0", in_ready);
        end
        step();
        total++;
        if ({in_ready, out_valid, out_sum, out_count, out_cnt_sat} !== {1'b0, 1'b1, 16'h03FC, 8'd4, 1'b0}) begin
            bad++;
            $display("FAIL b2b_result: rdy=%0b vld=%0b sum=%h cnt=%0d sat=%0b required 0 1 03fc 4 0",
                     in_ready, out_valid, out_sum, out_count, out_cnt_sat);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hFF;
            in_last  = (i == 299);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        step();
        total++;
        if ({out_valid, out_sum, out_count, out_cnt_sat} !== {1'b1, 16'h2AD4, 8'd255, 1'b1}) begin
            bad++;
            $display("FAIL saturate: vld=%0b sum=%h cnt=%0d sat=%0b required 1 2ad4 255 1",
                     out_valid, out_sum, out_count, out_cnt_sat);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_stall();
        send(8'h01, 1'b0);
        step();
        step();
        send(8'h02, 1'b0);
        step();
        step();
        send(8'h03, 1'b1);
        step();
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({out_valid, out_sum, out_count, out_cnt_sat} !== {1'b1, 16'h0006, 8'd3, 1'b0}) begin
                bad++;
                $display("FAIL stall_hold[%0d]: vld=%0b sum=%h cnt=%0d sat=%0b required 1 0006 3 0",
                         i, out_valid, out_sum, out_count, out_cnt_sat);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++;
        if ({out_valid, in_ready, out_sum} !== {1'b0, 1'b1, 16'h0006}) begin
            bad++;
            $display("FAIL stall_release: vld=%0b rdy=%0b sum=%h required 0 1 0006",
                     out_valid, in_ready, out_sum);
        end
    endtask

    task automatic test_reset_mid();
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        // Reset coincides with a would-be handshake; reset must win.
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h33;
        in_last  = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        total++;
        if ({in_ready, out_valid, out_sum, out_count} !== {1'b1, 1'b0, 16'h0, 8'h0}) begin
            bad++;
            $display("FAIL rst_mid: rdy=%0b vld=%0b sum=%h cnt=%0d required 1 0 0000 0",
                     in_ready, out_valid, out_sum, out_count);
        end
        send(8'h10, 1'b0);
        send(8'h20, 1'b1);
        step();
        total++;
        if ({out_valid, out_sum, out_count, out_cnt_sat} !== {1'b1, 16'h0030, 8'd2, 1'b0}) begin
            bad++;
            $display("FAIL rst_mid_batch: vld=%0b sum=%h cnt=%0d sat=%0b required 1 0030 2 0",
                     out_valid, out_sum, out_count, out_cnt_sat);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [ACC_W-1:0] exp_sum[$];
        logic [CNT_W-1:0] exp_cnt[$];
        logic [ACC_W-1:0] acc;
        logic [ACC_W-1:0] es;
        logic [CNT_W-1:0] ec;
        int nb;
        int sent_b;
        int idx;
        int len;
        int got;
        nb     = 6;
        sent_b = 0;
        idx    = 0;
        got    = 0;
        acc    = '0;
        len    = $urandom_range(1, 64);
        for (int cyc = 0; cyc < 20000 && got < nb; cyc++) begin
            if (sent_b < nb && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_data  = WIDTH'($urandom);
                in_last  = (idx == len - 1);
            end else begin
                in_valid = 1'b0;
                in_data  = WIDTH'($urandom);
                in_last  = 1'($urandom);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            if (out_valid && out_ready) begin
                total++;
                if (exp_sum.size() == 0) begin
                    bad++;
                    $display("FAIL rand_extra: unexpected result sum=%h cnt=%0d required none",
                             out_sum, out_count);
                end else begin
                    es = exp_sum.pop_front();
                    ec = exp_cnt.pop_front();
                    if (out_sum !== es || out_count !== ec) begin
                        bad++;
                        $display("FAIL rand_result[%0d]: sum=%h cnt=%0d required %h %0d",
                                 got, out_sum, out_count, es, ec);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                acc = acc + ACC_W'(in_data);
                idx++;
                if (in_last) begin
                    exp_sum.push_back(acc);
                    exp_cnt.push_back(CNT_W'(idx));
                    acc    = '0;
                    idx    = 0;
                    sent_b++;
                    len    = $urandom_range(1, 64);
                end
            end
            step();
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        total++;
        if (got != nb || exp_sum.size() != 0) begin
            bad++;
            $display("FAIL rand_count: results=%0d pending=%0d required %0d 0",
                     got, exp_sum.size(), nb);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_saturate();
        test_stall();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
